// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock LSB first, using a
// single full-subtractor cell, a borrow flip-flop and a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [WIDTH-1:0] part_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q, b_msb_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q, ovf_q;

  logic             a0, b0, di, bnext;
  logic [WIDTH-1:0] d_new;
  logic             last_bit;

  // ---------------------------------------------------------------------------
  // Full-subtractor cell and the difference as it will look after this edge
  // ---------------------------------------------------------------------------
  always_comb begin
    a0       = a_sh_q[0];
    b0       = b_sh_q[0];
    di       = a0 ^ b0 ^ br_q;
    bnext    = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    d_new    = {di, part_q[WIDTH-1:1]};
    last_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path assigned, so no latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    d    = d_q;
    bout = bout_q;
    ovf  = ovf_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, partial difference, borrow and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      part_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            part_q  <= '0;
            br_q    <= bin;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          part_q <= d_new;
          br_q   <= bnext;
          cnt_q  <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: only touched on the SHIFT -> DONE transition or reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_bit) begin
      d_q    <= d_new;
      bout_q <= bnext;
      // Operands of unlike sign whose result sign differs from the minuend's.
      ovf_q  <= (a_msb_q != b_msb_q) && (d_new[WIDTH-1] != a_msb_q);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): latency, arithmetic, borrow,
// signed overflow, start masking, held start and asynchronous reset.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             busy, done, bout, ovf;
  logic [WIDTH-1:0] d;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic bi);
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; returns how many falling edges it took.
  task automatic wait_done(output int cycles, output bit seen);
    seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, d, bout, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b d=%0d bout=%b ovf=%b, want all 0",
               busy, done, d, bout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_latency();
    int busy_cnt;
    launch(4'd6, 4'd3, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
      @(negedge clk);
    end
    total++;
    if (busy_cnt != 4) begin
      bad++;
      $display("FAIL latency_busy: got busy cycles=%0d, want 4", busy_cnt);
    end
    total++;
    if ({done, busy} !== 2'b10) begin
      bad++;
      $display("FAIL latency_done: got done=%b busy=%b on cycle 5, want 1 0", done, busy);
    end
    total++;
    if ({d, bout, ovf} !== {4'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_6_3: got d=%0d bout=%b ovf=%b, want 3 0 0", d, bout, ovf);
    end
    @(negedge clk);
    total++;
    if ({done, busy, d} !== {1'b0, 1'b0, 4'd3}) begin
      bad++;
      $display("FAIL done_pulse: got done=%b busy=%b d=%0d, want 0 0 3", done, busy, d);
    end
  endtask

  // Runs one operation and checks its result against hand-computed values.
  task automatic test_vector(input string name, input logic [WIDTH-1:0] av,
                             input logic [WIDTH-1:0] bv, input logic bi,
                             input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
    int  cyc;
    bit  seen;
    launch(av, bv, bi);
    wait_done(cyc, seen);
    total++;
    if (!seen || cyc != 4) begin
      bad++;
      $display("FAIL %s_timing: got seen=%0d after %0d cycles, want done after 4", name, seen, cyc);
    end
    total++;
    if ({d, bout, ovf} !== {ed, eb, eo}) begin
      bad++;
      $display("FAIL %s: got d=%0d bout=%b ovf=%b, want d=%0d bout=%b ovf=%b",
               name, d, bout, ovf, ed, eb, eo);
    end
    @(negedge clk);
  endtask

  task automatic test_borrow();
    test_vector("sub_3_6",     4'd3,  4'd6, 1'b0, 4'd13, 1'b1, 1'b0);
    test_vector("sub_0_0_b1",  4'd0,  4'd0, 1'b1, 4'd15, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    test_vector("sub_12_5_b1", 4'd12, 4'd5, 1'b1, 4'd6,  1'b0, 1'b1);
    test_vector("sub_12_3",    4'd12, 4'd3, 1'b0, 4'd9,  1'b0, 1'b0);
    test_vector("sub_8_1",     4'd8,  4'd1, 1'b0, 4'd7,  1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int  done_cnt;
    int  cyc;
    bit  seen;
    launch(4'd7, 4'd2, 1'b0);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (done === 1'b1) done_cnt++;
      if (k == 1) begin
        a = 4'd15; b = 4'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || done_cnt != 0) begin
      bad++;
      $display("FAIL masked_start_done: got done=%b early=%0d, want 1 0", done, done_cnt);
    end
    total++;
    if ({d, bout, ovf} !== {4'd5, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL masked_start_result: got d=%0d bout=%b ovf=%b, want 5 0 0", d, bout, ovf);
    end
    // Raise start during DONE and keep it high into IDLE.
    a = 4'd5; b = 4'd7; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL single_done: got done=%b busy=%b after DONE, want 0 0", done, busy);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL held_start_launch: got busy=%b, want 1", busy);
    end
    wait_done(cyc, seen);
    total++;
    if (!seen || {d, bout, ovf} !== {4'd14, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL held_start_result: got seen=%0d d=%0d bout=%b ovf=%b, want 1 14 1 0",
               seen, d, bout, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int done_cnt;
    launch(4'd9, 4'd1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, d, bout, ovf} !== '0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b d=%0d bout=%b ovf=%b, want all 0",
               busy, done, d, bout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL abandoned_op: got %0d busy/done cycles after reset, want 0", done_cnt);
    end
    test_vector("after_reset_10_7_b1", 4'd10, 4'd7, 1'b1, 4'd2, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_borrow();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, want finish before 50000");
    $fatal(1);
  end

endmodule
